// File: rtl/alu_defs_pkg.sv
// rtl/alu_defs_pkg.sv - ALU op field width and op encodings shared by the core and sequencer
package alu_defs_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] kADD = 4'h0;
  localparam logic [OPW-1:0] kSUB = 4'h1;
  localparam logic [OPW-1:0] kAND = 4'h2;
  localparam logic [OPW-1:0] kOR  = 4'h3;
  localparam logic [OPW-1:0] kXOR = 4'h4;

endpackage

// File: rtl/alu_mul_seq_if.sv
// rtl/alu_mul_seq_if.sv - multiply request, core ALU request and ALU mux bundle for alu_mul_seq
interface alu_mul_seq_if #(
  parameter int W   = 16,
  parameter int OPW = 4
);

  // multiply request / result
  logic             start;
  logic [W-1:0]     mcand;
  logic [W-1:0]     mplier;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  // core execute-stage ALU request
  logic             core_req;
  logic [OPW-1:0]   core_op;
  logic [W-1:0]     core_a;
  logic [W-1:0]     core_b;
  logic             core_ci;
  logic             core_grant;

  // shared ALU connection
  logic [OPW-1:0]   alu_op;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic             alu_ci;
  logic [W-1:0]     alu_out;
  logic             alu_co;

  // sequencer side
  modport slave (
    input  start, mcand, mplier,
    output busy, done, product,
    input  core_req, core_op, core_a, core_b, core_ci,
    output core_grant,
    output alu_op, alu_a, alu_b, alu_ci,
    input  alu_out, alu_co
  );

  // core / ALU side
  modport master (
    output start, mcand, mplier,
    input  busy, done, product,
    output core_req, core_op, core_a, core_b, core_ci,
    input  core_grant,
    input  alu_op, alu_a, alu_b, alu_ci,
    output alu_out, alu_co
  );

endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add unsigned multiply sequenced on the shared single-cycle ALU
module alu_mul_seq
  import alu_defs_pkg::*;
#(
  parameter int W   = 16,
  parameter int OPW = alu_defs_pkg::OPW
) (
  input  logic          CLK,
  input  logic          RESET,
  alu_mul_seq_if.slave  bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [W-1:0]  hi_q,    hi_d;
  logic [W-1:0]  lo_q,    lo_d;
  logic [W-1:0]  mc_q,    mc_d;
  logic          done_q,  done_d;

  logic           run;
  logic [OPW-1:0] alu_op_c;
  logic [W-1:0]   alu_a_c;
  logic [W-1:0]   alu_b_c;
  logic           alu_ci_c;

  assign run = (state_q == S_RUN);

  // next state: accept start in IDLE/DONE, one shift-add iteration per RUN cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mc_d    = mc_q;
    done_d  = 1'b0;
    case (state_q)
      S_RUN: begin
        // carry-out lands in the new hi MSB, so the 2W-bit product never overflows
        {hi_d, lo_d} = {bus.alu_co, bus.alu_out, lo_q[W-1:1]};
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; start in RUN is dropped
        if (bus.start) begin
          mc_d    = bus.mcand;
          lo_d    = bus.mplier;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // state and datapath registers; reset aborts any multiply in flight
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mc_q    <= mc_d;
      done_q  <= done_d;
    end
  end

  // ALU input mux: sequencer owns the ALU only in RUN, otherwise the core passes straight through
  always_comb begin
    alu_op_c = bus.core_op;
    alu_a_c  = bus.core_a;
    alu_b_c  = bus.core_b;
    alu_ci_c = bus.core_ci;
    if (run) begin
      alu_op_c = OPW'(kADD);
      alu_a_c  = hi_q;
      alu_b_c  = lo_q[0] ? mc_q : '0;
      alu_ci_c = 1'b0;
    end
  end

  assign bus.alu_op     = alu_op_c;
  assign bus.alu_a      = alu_a_c;
  assign bus.alu_b      = alu_b_c;
  assign bus.alu_ci     = alu_ci_c;

  assign bus.core_grant = bus.core_req & ~run;
  assign bus.busy       = run;
  assign bus.done       = done_q;
  assign bus.product    = {hi_q, lo_q};

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - self-checking scoreboard bench for alu_mul_seq
module tb_alu_mul_seq;
  import alu_defs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  alu_mul_seq_if #(.W(16), .OPW(4)) bus ();

  alu_mul_seq #(.W(16), .OPW(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  // behavioural single-cycle ALU
  logic [16:0] alu_res;
  always_comb begin
    case (bus.alu_op)
      kADD:    alu_res = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'h0, bus.alu_ci};
      kAND:    alu_res = {1'b0, bus.alu_a & bus.alu_b};
      default: alu_res = {1'b0, bus.alu_a ^ bus.alu_b};
    endcase
  end
  assign bus.alu_out = alu_res[15:0];
  assign bus.alu_co  = alu_res[16];

  logic [31:0] sb [$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one multiply and wait for done; results returned for the caller to judge
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int busy_cnt,
                        output logic [31:0] prod, output bit to);
    bus.mcand  = a;
    bus.mplier = b;
    bus.start  = 1'b1;
    sb.push_back({16'h0, a} * {16'h0, b});
    tick();
    bus.start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    to = 1'b1;
    prod = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        prod = bus.product;
        to = 1'b0;
        break;
      end
      tick();
      lat++;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.mcand = '0; bus.mplier = '0;
    bus.core_req = 1'b1; bus.core_op = kADD;
    bus.core_a = 16'd4; bus.core_b = 16'd4; bus.core_ci = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.product !== 32'h0) begin n_fail++; $display("FAIL reset_product: got %h expected 00000000", bus.product); end
    n_cmp++; if (bus.core_grant !== 1'b1) begin n_fail++; $display("FAIL reset_grant: got %b expected 1", bus.core_grant); end
    n_cmp++; if (bus.alu_op !== kADD || bus.alu_a !== 16'd4 || bus.alu_b !== 16'd4)
      begin n_fail++; $display("FAIL reset_alu_mirror: got op=%h a=%h b=%h expected op=%h a=0004 b=0004", bus.alu_op, bus.alu_a, bus.alu_b, kADD); end
    tick();
    bus.core_req = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc; logic [31:0] p, e; bit to;
    do_mul(16'h0003, 16'h0005, lat, bc, p, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL basic_timeout: got no done expected done"); end
    n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL basic_latency: got %0d expected 17", lat); end
    n_cmp++; if (bc !== 16) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 16", bc); end
    e = sb.pop_front();
    n_cmp++; if (p !== e) begin n_fail++; $display("FAIL basic_product: got %h expected %h", p, e); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_single: got %b expected 0", bus.done); end
    n_cmp++; if (bus.product !== e) begin n_fail++; $display("FAIL basic_product_hold: got %h expected %h", bus.product, e); end
    tick();
  endtask

  task automatic test_patterns();
    int lat, bc; logic [31:0] p, e; bit to;
    logic [15:0] av [3] = '{16'hFFFF, 16'h1234, 16'hA5A5};
    logic [15:0] bv [3] = '{16'hFFFF, 16'h0000, 16'h5A5A};
    for (int k = 0; k < 3; k++) begin
      do_mul(av[k], bv[k], lat, bc, p, to);
      e = sb.pop_front();
      n_cmp++; if (to || p !== e) begin n_fail++; $display("FAIL pattern_%0d_product: got %h expected %h", k, p, e); end
    end
  endtask

  task automatic test_arbitration();
    logic [31:0] e;
    bus.core_req = 1'b1; bus.core_op = kSUB;
    bus.core_a = 16'hAAAA; bus.core_b = 16'h5555;
    bus.mcand = 16'h00FF; bus.mplier = 16'h0101; bus.start = 1'b1;
    sb.push_back(32'h0000FFFF);
    @(negedge clk);
    n_cmp++; if (bus.core_grant !== 1'b1) begin n_fail++; $display("FAIL arb_start_grant: got %b expected 1", bus.core_grant); end
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.core_grant !== 1'b0 || bus.alu_op !== kADD || bus.busy !== 1'b1)
        begin n_fail++; $display("FAIL arb_run_cycle_%0d: got grant=%b op=%h busy=%b expected grant=0 op=%h busy=1", c, bus.core_grant, bus.alu_op, bus.busy, kADD); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL arb_done: got %b expected 1", bus.done); end
    n_cmp++; if (bus.core_grant !== 1'b1 || bus.alu_a !== 16'hAAAA || bus.alu_op !== kSUB)
      begin n_fail++; $display("FAIL arb_done_grant: got grant=%b a=%h op=%h expected grant=1 a=aaaa op=%h", bus.core_grant, bus.alu_a, bus.alu_op, kSUB); end
    e = sb.pop_front();
    n_cmp++; if (bus.product !== e) begin n_fail++; $display("FAIL arb_product: got %h expected %h", bus.product, e); end
    tick();
    bus.core_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    int cyc;
    bit seen;
    bus.mcand = 16'h0003; bus.mplier = 16'h0005; bus.start = 1'b1;
    sb.push_back(32'h0000000F);
    tick();
    seen = 1'b0; cyc = 1;
    for (int i = 1; i < 40; i++) begin
      cyc = i;
      if (i == 5) begin
        bus.start = 1'b1; bus.mcand = 16'h0009; bus.mplier = 16'h0009;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; break; end
      tick();
    end
    n_cmp++; if (!seen || cyc !== 17) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 17", cyc); end
    e = sb.pop_front();
    n_cmp++; if (bus.product !== e) begin n_fail++; $display("FAIL b2b_ignored_start: got %h expected %h", bus.product, e); end
    // request again in the DONE cycle
    bus.mcand = 16'h1234; bus.mplier = 16'h0010; bus.start = 1'b1;
    sb.push_back(32'h00012340);
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_idle: got busy=%b expected 1", bus.busy); end
    tick();
    seen = 1'b0; cyc = 2;
    for (int i = 2; i < 40; i++) begin
      cyc = i;
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; break; end
      tick();
    end
    n_cmp++; if (!seen || cyc !== 17) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 17", cyc); end
    e = sb.pop_front();
    n_cmp++; if (bus.product !== e) begin n_fail++; $display("FAIL b2b_second_product: got %h expected %h", bus.product, e); end
    tick();
  endtask

  task automatic test_reset_abort();
    int lat, bc; logic [31:0] p, e; bit to;
    bus.mcand = 16'hFFFF; bus.mplier = 16'hFFFF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b expected 1", bus.busy); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 32'h0)
      begin n_fail++; $display("FAIL abort_immediate: got busy=%b done=%b product=%h expected 0 0 00000000", bus.busy, bus.done, bus.product); end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0)
        begin n_fail++; $display("FAIL abort_hold_%0d: got busy=%b done=%b expected 0 0", i, bus.busy, bus.done); end
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL abort_release: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    tick();
    do_mul(16'd7, 16'd6, lat, bc, p, to);
    e = sb.pop_front();
    n_cmp++; if (to || lat !== 17) begin n_fail++; $display("FAIL abort_after_latency: got %0d expected 17", lat); end
    n_cmp++; if (p !== e) begin n_fail++; $display("FAIL abort_after_product: got %h expected %h", p, e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_arbitration();
    test_back_to_back();
    test_reset_abort();
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Sequences a 16x16 unsigned multiply on the shared single-cycle ALU with a shift-add loop: one ALU add per iteration, W iterations, 32-bit product.
- Owns the ALU input mux. The core's execute stage drives the ALU directly whenever the sequencer is not running. While a multiply runs, the core is denied the ALU through core_grant.
- Sits beside the ALU in the execute stage. The core stalls on busy or on a denied grant.

Parameters:
- W, 16, datapath width; number of iterations; product width is 2*W.
- OPW, 4, width of the ALU op field; encodings are the definitions package constants (kADD used internally).

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- start  in  1  multiply request; sampled only in IDLE or DONE
- mcand  in  W  multiplicand, captured on accepted start
- mplier  in  W  multiplier, captured on accepted start
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, product valid
- product  out  2W  {hi,lo}; holds until next accepted start
- core_req  in  1  core wants the ALU this cycle
- core_op  in  OPW  core ALU op
- core_a, core_b  in  W  core operands
- core_ci  in  1  core carry-in
- core_grant  out  1  core owns the ALU this cycle
- alu_op  out  OPW  to ALU OP
- alu_a, alu_b  out  W  to ALU INPUTA/INPUTB
- alu_ci  out  1  to ALU CI
- alu_out  in  W  ALU result
- alu_co  in  1  ALU carry-out

Behaviour:
- States: IDLE, RUN, DONE. Registers: state, cnt (clog2(W) bits), hi (W), lo (W), mc (W), done.
- Reset (async, immediate): state=IDLE, cnt=0, hi=lo=mc=0, done=0. Outputs then read busy=0, product=0, core_grant=core_req.
- Start acceptance:
  - In IDLE or DONE with start=1, the edge loads mc=mcand, lo=mplier, hi=0, cnt=0, and moves to RUN.
  - start in RUN is ignored; requests are not queued.
- RUN datapath (per cycle):
  - alu_op=kADD, alu_a=hi, alu_b = lo[0] ? mc : 0, alu_ci=0.
  - At the edge: {hi,lo} <= {alu_co, alu_out, lo[W-1:1]}; cnt <= cnt+1.
- RUN exit:
  - When cnt==W-1 at an edge, the last iteration completes and the next state is DONE.
  - RUN lasts exactly W cycles.
- DONE lasts one cycle with done=1. Next state is RUN if start=1, otherwise IDLE.
- Latency: start sampled at edge k; done is high in the cycle after edge k+W (W+1 cycles after the start cycle).
- Arbitration:
  - core_grant = core_req and state!=RUN. This is combinational; the core is never granted during RUN.
  - When state!=RUN, the alu_* ports are driven from core_op/core_a/core_b/core_ci, regardless of core_req.
  - When start and core_req coincide in IDLE/DONE, the core is granted that cycle and the multiply begins at the next edge.
- busy = (state==RUN). done is registered. product = {hi,lo}, a direct register output.
- hi/lo keep updating only in RUN, so product stays stable through DONE and IDLE.
- Arithmetic: unsigned only. The carry out of the add becomes the new hi MSB, so there is no overflow at 2W bits.
- Reset asserted mid-RUN aborts the operation. No done pulse is issued for the aborted multiply.

Test Plan:
1. Apply RESET, then release -> busy=0, done=0, product=0x00000000; with core_req=1 and core_op=kADD, core_a=4, core_b=4: core_grant=1 and alu_op/a/b mirror the core inputs.
2. start=1 with mcand=0x0003, mplier=0x0005 -> busy high for exactly 16 cycles, done pulses once 17 cycles after the start cycle, product=0x0000000F.
3. mcand=0xFFFF, mplier=0xFFFF -> product=0xFFFE0001 (carry path exercised); mcand=0x1234, mplier=0 -> product=0x00000000.
4. Hold core_req=1 throughout a multiply -> core_grant=0 and alu_op=kADD for all 16 RUN cycles; in the DONE cycle core_grant=1 and alu_a=core_a.
5. Pulse start=1 in RUN cycle 5 with new operands -> ignored, result still 0x0000000F. Then start=1 in the DONE cycle with mcand=0x1234, mplier=0x0010 -> RUN is re-entered with no IDLE cycle, second product=0x00012340.
6. Assert RESET during RUN iteration 8 -> busy, done and product read 0 immediately, state IDLE, no done pulse. After release, mcand=7, mplier=6 -> product=0x0000002A.
